// File: rtl/tmr_rollback_ctrl.sv
// tmr_rollback_ctrl
// Rollback and checkpoint sequencer that sits between the TMR majority voter
// and the shared instruction/data muxes of the lockstep RISC-V cluster.
//   - Voter mismatch: restore the faulting instruction's registers from the
//     shadow area with injected loads, then replay the instruction.
//   - Voted commit: checkpoint the destination register with an injected store.
// Shadow slot for register r lives at SHADOW_BASE + r*(XLEN/8), addressed off x0.
// All outputs are registered decodes of the state register, so they trail the
// state by one cycle.
// Build option: define TMR_RETRY_LIMIT_EN to add the consecutive-recovery
// counter and the absorbing FATAL state (bounded by MAX_RETRY).

module tmr_rollback_ctrl #(
    parameter int XLEN                = 64,
    parameter int SHADOW_BASE         = 0,
    parameter int RECOVER_ON_MINORITY = 0,
    parameter int MAX_RETRY           = 3
) (
    input  logic            clk,
    input  logic            rst_in,
    input  logic [2:0]      voter_state,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_in,
    output logic [31:0]     inj_instr,
    output logic            inj_sel,
    output logic            data_sel,
    output logic            wr_en,
    output logic            core_hold,
    output logic            recovery_mode,
    output logic [XLEN-1:0] pc_out,
    output logic            fatal
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int         SLOT_BYTES = XLEN / 8;
    localparam logic [2:0] LS_FUNCT3  = (XLEN == 64) ? 3'b011 : 3'b010;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("tmr_rollback_ctrl: XLEN must be 32 or 64");
    end

    if (SHADOW_BASE < 0 || (SHADOW_BASE + 31 * SLOT_BYTES) > 2047) begin : g_bad_base
        $error("tmr_rollback_ctrl: shadow area does not fit a 12-bit signed offset off x0");
    end

    if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_retry
        $error("tmr_rollback_ctrl: MAX_RETRY must be within 1..15");
    end

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RST_RD  = 3'd1,
        RST_RS1 = 3'd2,
        RST_RS2 = 3'd3,
        REPLAY  = 3'd4,
        CKPT_ST = 3'd5,
        FATAL   = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Instruction encoding helpers
    // ------------------------------------------------------------------

    // Byte offset of the shadow slot for register r.
    function automatic logic [11:0] slot_off(input logic [4:0] r);
        slot_off = 12'(SHADOW_BASE + int'(r) * SLOT_BYTES);
    endfunction

    // I-type load: rd = r, rs1 = x0, imm = slot offset of r.
    function automatic logic [31:0] enc_load(input logic [4:0] r);
        logic [11:0] imm;
        imm      = slot_off(r);
        enc_load = {imm, 5'd0, LS_FUNCT3, r, OP_LOAD};
    endfunction

    // S-type store: rs2 = r, rs1 = x0, imm = slot offset of r.
    function automatic logic [31:0] enc_store(input logic [4:0] r);
        logic [11:0] imm;
        imm       = slot_off(r);
        enc_store = {imm[11:5], r, 5'd0, LS_FUNCT3, imm[4:0], OP_STORE};
    endfunction

    // Stores and branches carry no destination register.
    function automatic logic writes_rd(input logic [31:0] ins);
        writes_rd = (ins[6:0] != OP_STORE) && (ins[6:0] != OP_BRANCH);
    endfunction

    // First restore step after 'from' whose register field is nonzero;
    // falls through to REPLAY when no further register needs restoring.
    function automatic state_t next_restore(input state_t from, input logic [31:0] ins);
        next_restore = REPLAY;
        case (from)
            IDLE: begin
                if (ins[11:7] != 5'd0) begin
                    next_restore = RST_RD;
                end else if (ins[19:15] != 5'd0) begin
                    next_restore = RST_RS1;
                end else if (ins[24:20] != 5'd0) begin
                    next_restore = RST_RS2;
                end else begin
                    next_restore = REPLAY;
                end
            end
            RST_RD: begin
                if (ins[19:15] != 5'd0) begin
                    next_restore = RST_RS1;
                end else if (ins[24:20] != 5'd0) begin
                    next_restore = RST_RS2;
                end else begin
                    next_restore = REPLAY;
                end
            end
            RST_RS1: begin
                if (ins[24:20] != 5'd0) begin
                    next_restore = RST_RS2;
                end else begin
                    next_restore = REPLAY;
                end
            end
            default: next_restore = REPLAY;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Registers and internal signals
    // ------------------------------------------------------------------
    state_t            state_r;
    logic [31:0]       cap_instr_r;
    logic [XLEN-1:0]   cap_pc_r;

    logic              mismatch_s;
    logic              commit_s;
    logic              retry_exhausted_s;

    logic [31:0]       inj_instr_s;
    logic              inj_sel_s;
    logic              data_sel_s;
    logic              wr_en_s;
    logic              core_hold_s;
    logic              recovery_mode_s;
    logic [XLEN-1:0]   pc_out_s;
    logic              fatal_s;

    // Classify the voter result of the instruction presented this cycle.
    always_comb begin
        mismatch_s = 1'b0;
        if (!instr_valid) begin
            mismatch_s = 1'b0;
        end else if (voter_state == 3'b000) begin
            mismatch_s = 1'b1;
        end else if ((RECOVER_ON_MINORITY != 0) && (voter_state != 3'b111)) begin
            mismatch_s = 1'b1;
        end else begin
            mismatch_s = 1'b0;
        end
    end

    assign commit_s = instr_valid & ~mismatch_s;

`ifdef TMR_RETRY_LIMIT_EN
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    logic [3:0] retry_cnt_r;

    // Count back-to-back recovery entries; any voted commit clears the count.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            retry_cnt_r <= 4'd0;
        end else if (state_r == IDLE && mismatch_s && !retry_exhausted_s) begin
            retry_cnt_r <= retry_cnt_r + 4'd1;
        end else if (state_r == IDLE && commit_s) begin
            retry_cnt_r <= 4'd0;
        end else begin
            retry_cnt_r <= retry_cnt_r;
        end
    end

    assign retry_exhausted_s = (retry_cnt_r == RETRY_LIMIT);
`else
    assign retry_exhausted_s = 1'b0;
`endif

    // Sequencer: walks restore steps, replay and checkpoint; captures the event.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_r     <= IDLE;
            cap_instr_r <= 32'h0000_0000;
            cap_pc_r    <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (mismatch_s && retry_exhausted_s) begin
                        state_r <= FATAL;
                    end else if (mismatch_s) begin
                        cap_instr_r <= instr;
                        cap_pc_r    <= pc_in;
                        state_r     <= next_restore(IDLE, instr);
                    end else if (commit_s && writes_rd(instr) && (instr[11:7] != 5'd0)) begin
                        cap_instr_r <= instr;
                        state_r     <= CKPT_ST;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RST_RD:  state_r <= next_restore(RST_RD, cap_instr_r);
                RST_RS1: state_r <= next_restore(RST_RS1, cap_instr_r);
                RST_RS2: state_r <= REPLAY;
                REPLAY:  state_r <= IDLE;
                CKPT_ST: state_r <= IDLE;
`ifdef TMR_RETRY_LIMIT_EN
                FATAL:   state_r <= FATAL;
`endif
                default: state_r <= IDLE;
            endcase
        end
    end

    // Decode the mux/control values belonging to the current state.
    always_comb begin
        inj_instr_s     = 32'h0000_0000;
        inj_sel_s       = 1'b0;
        data_sel_s      = 1'b0;
        wr_en_s         = 1'b0;
        core_hold_s     = 1'b0;
        recovery_mode_s = 1'b0;
        pc_out_s        = {XLEN{1'b0}};
        fatal_s         = 1'b0;
        case (state_r)
            IDLE: begin
                inj_sel_s = 1'b0;
            end
            RST_RD: begin
                inj_instr_s     = enc_load(cap_instr_r[11:7]);
                inj_sel_s       = 1'b1;
                data_sel_s      = 1'b1;
                core_hold_s     = 1'b1;
                recovery_mode_s = 1'b1;
                pc_out_s        = cap_pc_r;
            end
            RST_RS1: begin
                inj_instr_s     = enc_load(cap_instr_r[19:15]);
                inj_sel_s       = 1'b1;
                data_sel_s      = 1'b1;
                core_hold_s     = 1'b1;
                recovery_mode_s = 1'b1;
                pc_out_s        = cap_pc_r;
            end
            RST_RS2: begin
                inj_instr_s     = enc_load(cap_instr_r[24:20]);
                inj_sel_s       = 1'b1;
                data_sel_s      = 1'b1;
                core_hold_s     = 1'b1;
                recovery_mode_s = 1'b1;
                pc_out_s        = cap_pc_r;
            end
            REPLAY: begin
                inj_instr_s     = cap_instr_r;
                inj_sel_s       = 1'b1;
                core_hold_s     = 1'b1;
                recovery_mode_s = 1'b1;
                pc_out_s        = cap_pc_r;
            end
            CKPT_ST: begin
                inj_instr_s = enc_store(cap_instr_r[11:7]);
                inj_sel_s   = 1'b1;
                wr_en_s     = 1'b1;
                core_hold_s = 1'b1;
            end
`ifdef TMR_RETRY_LIMIT_EN
            FATAL: begin
                core_hold_s = 1'b1;
                fatal_s     = 1'b1;
            end
`endif
            default: begin
                inj_sel_s = 1'b0;
            end
        endcase
    end

    // Output register stage so every control line leaves the block from a flop.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            inj_instr     <= 32'h0000_0000;
            inj_sel       <= 1'b0;
            data_sel      <= 1'b0;
            wr_en         <= 1'b0;
            core_hold     <= 1'b0;
            recovery_mode <= 1'b0;
            pc_out        <= {XLEN{1'b0}};
            fatal         <= 1'b0;
        end else begin
            inj_instr     <= inj_instr_s;
            inj_sel       <= inj_sel_s;
            data_sel      <= data_sel_s;
            wr_en         <= wr_en_s;
            core_hold     <= core_hold_s;
            recovery_mode <= recovery_mode_s;
            pc_out        <= pc_out_s;
            fatal         <= fatal_s;
        end
    end

endmodule

// File: tb/tb_tmr_rollback_ctrl.sv
// Bench for tmr_rollback_ctrl. Two instances share the voter/instruction
// stimulus:
//   a: XLEN=64, SHADOW_BASE=0,   RECOVER_ON_MINORITY=0, MAX_RETRY=2
//   b: XLEN=32, SHADOW_BASE=128, RECOVER_ON_MINORITY=1, MAX_RETRY=2
// A behavioural model keeps, per instance, the list of actions still owed
// after an accepted event and predicts the outputs after every edge.
`timescale 1ns/1ps

module tb_tmr_rollback_ctrl;

`ifdef TMR_RETRY_LIMIT_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam logic [31:0] ADD  = 32'h0073_02B3;  // add  x5,x6,x7
    localparam logic [31:0] ADDI = 32'h0003_0013;  // addi x0,x6,0
    localparam logic [31:0] NOP  = 32'h0000_0013;  // addi x0,x0,0

    typedef struct packed {
        logic [31:0] inj_instr;
        logic        inj_sel;
        logic        data_sel;
        logic        wr_en;
        logic        core_hold;
        logic        recovery_mode;
        logic [63:0] pc_out;
        logic        fatal;
    } obs_t;

    logic        clk;
    logic        rst_in;
    logic [2:0]  voter_state;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] pc;

    logic [31:0] a_inj_instr, b_inj_instr;
    logic        a_inj_sel, a_data_sel, a_wr_en, a_core_hold, a_recovery_mode, a_fatal;
    logic        b_inj_sel, b_data_sel, b_wr_en, b_core_hold, b_recovery_mode, b_fatal;
    logic [63:0] a_pc_out;
    logic [31:0] b_pc_out;

    int   total = 0;
    int   bad   = 0;
    bit   live  = 1'b0;

    obs_t exp_obs [2];
    obs_t pend    [2][4];
    int   pend_n  [2];
    int   pend_i  [2];
    int   rcnt    [2];
    bit   fat     [2];

    tmr_rollback_ctrl #(.XLEN(64), .SHADOW_BASE(0), .RECOVER_ON_MINORITY(0), .MAX_RETRY(2)) dut_a (
        .clk(clk), .rst_in(rst_in), .voter_state(voter_state), .instr_valid(instr_valid),
        .instr(instr), .pc_in(pc), .inj_instr(a_inj_instr), .inj_sel(a_inj_sel),
        .data_sel(a_data_sel), .wr_en(a_wr_en), .core_hold(a_core_hold),
        .recovery_mode(a_recovery_mode), .pc_out(a_pc_out), .fatal(a_fatal)
    );

    tmr_rollback_ctrl #(.XLEN(32), .SHADOW_BASE(128), .RECOVER_ON_MINORITY(1), .MAX_RETRY(2)) dut_b (
        .clk(clk), .rst_in(rst_in), .voter_state(voter_state), .instr_valid(instr_valid),
        .instr(instr), .pc_in(pc[31:0]), .inj_instr(b_inj_instr), .inj_sel(b_inj_sel),
        .data_sel(b_data_sel), .wr_en(b_wr_en), .core_hold(b_core_hold),
        .recovery_mode(b_recovery_mode), .pc_out(b_pc_out), .fatal(b_fatal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic int xlen_of(input int d);
        return (d == 0) ? 64 : 32;
    endfunction

    function automatic int base_of(input int d);
        return (d == 0) ? 0 : 128;
    endfunction

    function automatic bit rom_of(input int d);
        return (d == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic longint funct3_of(input int d);
        return (xlen_of(d) == 64) ? 64'd3 : 64'd2;
    endfunction

    function automatic logic [31:0] m_load(input int d, input int r);
        longint imm;
        imm = longint'(base_of(d) + r * (xlen_of(d) / 8));
        return 32'(imm * 1048576 + funct3_of(d) * 4096 + longint'(r) * 128 + 3);
    endfunction

    function automatic logic [31:0] m_store(input int d, input int r);
        longint imm;
        imm = longint'(base_of(d) + r * (xlen_of(d) / 8));
        return 32'((imm / 32) * 33554432 + longint'(r) * 1048576 + funct3_of(d) * 4096
                   + (imm % 32) * 128 + 35);
    endfunction

    function automatic obs_t mk(input logic [31:0] ins, input logic sel, input logic dsel,
                                input logic we, input logic hold, input logic rec,
                                input logic [63:0] p, input logic f);
        obs_t o;
        o.inj_instr = ins; o.inj_sel = sel; o.data_sel = dsel; o.wr_en = we;
        o.core_hold = hold; o.recovery_mode = rec; o.pc_out = p; o.fatal = f;
        return o;
    endfunction

    function automatic obs_t idle_obs();
        return mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    endfunction

    task automatic model_edge(input int d);
        logic        mm;
        logic [63:0] pcm;
        logic [4:0]  f [3];
        if (rst_in) begin
            exp_obs[d] = idle_obs();
            pend_n[d] = 0; pend_i[d] = 0; rcnt[d] = 0; fat[d] = 1'b0;
        end else begin
            if (fat[d])                      exp_obs[d] = mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
            else if (pend_i[d] < pend_n[d])  exp_obs[d] = pend[d][pend_i[d]];
            else                             exp_obs[d] = idle_obs();

            if (!fat[d] && pend_i[d] < pend_n[d]) begin
                pend_i[d]++;
            end else if (!fat[d]) begin
                pend_n[d] = 0; pend_i[d] = 0;
                mm  = instr_valid && (voter_state == 3'b000 || (rom_of(d) && voter_state != 3'b111));
                pcm = (d == 0) ? pc : {32'h0, pc[31:0]};
                f[0] = instr[11:7]; f[1] = instr[19:15]; f[2] = instr[24:20];
                if (mm) begin
                    if (RETRY_EN && rcnt[d] == 2) begin
                        fat[d] = 1'b1;
                    end else begin
                        rcnt[d]++;
                        for (int k = 0; k < 3; k++) begin
                            if (f[k] != 5'd0) begin
                                pend[d][pend_n[d]] = mk(m_load(d, int'(f[k])), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, pcm, 1'b0);
                                pend_n[d]++;
                            end
                        end
                        pend[d][pend_n[d]] = mk(instr, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, pcm, 1'b0);
                        pend_n[d]++;
                    end
                end else if (instr_valid) begin
                    rcnt[d] = 0;
                    if (instr[6:0] != 7'h23 && instr[6:0] != 7'h63 && f[0] != 5'd0) begin
                        pend[d][0] = mk(m_store(d, int'(f[0])), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
                        pend_n[d] = 1;
                    end
                end
            end
        end
    endtask

    // model advances on every rising edge
    initial forever begin
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d);
    end

    // compare process: every falling edge once the bench is live
    initial forever begin
        obs_t act;
        @(negedge clk);
        if (live) begin
            act = {a_inj_instr, a_inj_sel, a_data_sel, a_wr_en, a_core_hold, a_recovery_mode, a_pc_out, a_fatal};
            total++;
            if (act !== exp_obs[0]) begin
                bad++;
                $display("FAIL model_a t=%0t: got %h want %h", $time, act, exp_obs[0]);
            end
            act = {b_inj_instr, b_inj_sel, b_data_sel, b_wr_en, b_core_hold, b_recovery_mode, {32'h0, b_pc_out}, b_fatal};
            total++;
            if (act !== exp_obs[1]) begin
                bad++;
                $display("FAIL model_b t=%0t: got %h want %h", $time, act, exp_obs[1]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // present one event for a single edge; returns just after that edge
    task automatic pulse(input logic [2:0] v, input logic [31:0] ins, input logic [63:0] p);
        voter_state = v; instr = ins; pc = p; instr_valid = 1'b1;
        tick(1);
        instr_valid = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; instr_valid = 1'b0; voter_state = 3'b111; instr = 32'h0; pc = 64'h0;
        tick(3);
        rst_in = 1'b0; live = 1'b1;
        lit("reset_inj_instr", 64'(a_inj_instr), 64'h0);
        lit("reset_inj_sel", 64'(a_inj_sel), 64'h0);
        lit("reset_core_hold", 64'(a_core_hold), 64'h0);
        lit("reset_pc_out", a_pc_out, 64'h0);
        lit("reset_fatal", 64'(a_fatal), 64'h0);
        tick(1);

        // full recovery of add x5,x6,x7
        pulse(3'b000, ADD, 64'h0000_0001_8000_1000);
        tick(1);
        lit("rec_rd_load", 64'(a_inj_instr), 64'h0280_3283);
        lit("rec_data_sel", 64'(a_data_sel), 64'h1);
        lit("rec_pc_out", a_pc_out, 64'h0000_0001_8000_1000);
        lit("rec_b_rd_load", 64'(b_inj_instr), 64'h0940_2283);
        tick(1);
        lit("rec_rs1_load", 64'(a_inj_instr), 64'h0300_3303);
        tick(1);
        lit("rec_rs2_load", 64'(a_inj_instr), 64'h0380_3383);
        tick(1);
        lit("rec_replay", 64'(a_inj_instr), 64'h0073_02B3);
        lit("rec_replay_dsel", 64'(a_data_sel), 64'h0);
        lit("rec_replay_mode", 64'(a_recovery_mode), 64'h1);
        tick(1);
        lit("rec_done_sel", 64'(a_inj_sel), 64'h0);
        tick(2);

        // checkpoint of x5
        pulse(3'b111, ADD, 64'h0000_0000_0000_2000);
        tick(1);
        lit("ckpt_store", 64'(a_inj_instr), 64'h0250_3423);
        lit("ckpt_wr_en", 64'(a_wr_en), 64'h1);
        lit("ckpt_hold", 64'(a_core_hold), 64'h1);
        lit("ckpt_b_store", 64'(b_inj_instr), 64'h0850_2A23);
        tick(1);
        lit("ckpt_one_cycle", 64'(a_wr_en), 64'h0);
        tick(2);

        // rd=x0, rs2=x0: only rs1 restored, then replay
        pulse(3'b000, ADDI, 64'h0000_0000_0000_3000);
        tick(1);
        lit("x0skip_rs1", 64'(a_inj_instr), 64'h0300_3303);
        lit("x0skip_b_rs1", 64'(b_inj_instr), 64'h0980_2303);
        tick(1);
        lit("x0skip_replay", 64'(a_inj_instr), 64'h0003_0013);
        tick(1);
        lit("x0skip_done", 64'(a_inj_sel), 64'h0);
        tick(2);

        // minority disagreement: a checkpoints, b recovers
        pulse(3'b110, ADD, 64'h0000_0000_0000_4000);
        tick(1);
        lit("minor_a_ckpt", 64'(a_inj_instr), 64'h0250_3423);
        lit("minor_b_recover", 64'(b_recovery_mode), 64'h1);
        tick(5);
        // commit without destination: counters clear, nothing injected
        pulse(3'b111, NOP, 64'h0);
        tick(1);
        lit("nop_no_inject", 64'(a_inj_sel), 64'h0);
        tick(1);

        // back-to-back: recovery, then commits held on the valid line
        voter_state = 3'b000; instr = ADDI; pc = 64'h0000_0000_0000_5000; instr_valid = 1'b1;
        tick(1);
        voter_state = 3'b111; instr = ADD;
        tick(3);
        lit("b2b_gap", 64'(a_inj_sel), 64'h0);
        tick(1);
        lit("b2b_first_ckpt", 64'(a_inj_instr), 64'h0250_3423);
        tick(1);
        instr_valid = 1'b0;
        lit("b2b_between", 64'(a_wr_en), 64'h0);
        tick(1);
        lit("b2b_second_ckpt", 64'(a_wr_en), 64'h1);
        tick(2);

        // reset during RST_RS1 aborts the sequence
        pulse(3'b000, ADD, 64'h0000_0000_0000_6000);
        tick(1);
        lit("abort_rd_seen", 64'(a_inj_instr), 64'h0280_3283);
        rst_in = 1'b1;
        tick(1);
        rst_in = 1'b0;
        lit("abort_inj_sel", 64'(a_inj_sel), 64'h0);
        lit("abort_inj_instr", 64'(a_inj_instr), 64'h0);
        lit("abort_pc_out", a_pc_out, 64'h0);
        tick(1);
        pulse(3'b111, ADD, 64'h0000_0000_0000_7000);
        tick(1);
        lit("post_abort_ckpt", 64'(a_inj_instr), 64'h0250_3423);
        tick(2);

        // three mismatches in a row without a commit
        for (int k = 0; k < 2; k++) begin
            pulse(3'b000, ADD, 64'h0000_0000_0000_8000);
            tick(6);
        end
        pulse(3'b000, ADD, 64'h0000_0000_0000_8000);
        tick(1);
        lit("retry_fatal", 64'(a_fatal), 64'(RETRY_EN));
        lit("retry_hold", 64'(a_core_hold), 64'h1);
        lit("retry_inj_sel", 64'(a_inj_sel), 64'(!RETRY_EN));
        tick(5);
        pulse(3'b111, ADD, 64'h0);
        tick(2);
        lit("fatal_sticky", 64'(a_fatal), 64'(RETRY_EN));
        rst_in = 1'b1;
        tick(1);
        rst_in = 1'b0;
        lit("fatal_cleared", 64'(a_fatal), 64'h0);
        lit("fatal_hold_cleared", 64'(a_core_hold), 64'h0);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
